// File: rtl/reaction_pkg.sv
// Shared state encoding, LFSR constants and time width for the reaction timer.
package reaction_pkg;

  localparam int          MS_W      = 14;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    GO    = 3'd2,
    DONE  = 3'd3,
    CHEAT = 3'd4
  } state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = {1'b0, cur[15:1]};
    if (cur[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick at terminal count, synchronous clear.
module ms_tick_gen #(
  parameter int CLK_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W = $clog2(CLK_PER_MS);
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLK_PER_MS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: wrap at terminal count, restart on clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == TERM)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == TERM);

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time controller: random wait, GO LED, millisecond count until stop.
// Build option: define BEST_TIME_EN to keep the best stop-terminated time in best_ms.
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int CLK_PER_MS   = 50000,
  parameter int DELAY_MIN_MS = 1000,
  parameter int DELAY_BITS   = 11,
  parameter int MAX_MS       = 9999
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  output logic [MS_W-1:0] time_ms,
  output logic            go_led,
  output logic            done,
  output logic            cheat,
  output logic [2:0]      state,
  output logic [MS_W-1:0] best_ms
);

  localparam int              DLY_W = $clog2(DELAY_MIN_MS + (1 << DELAY_BITS));
  localparam logic [MS_W-1:0] MAX_T = MS_W'(MAX_MS);

  state_e           state_q, state_d;
  logic [MS_W-1:0]  time_q, time_d, time_inc_s;
  logic [DLY_W-1:0] delay_q, delay_d, delay_load_s;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             start_q, stop_q;
  logic             start_ev_s, stop_ev_s, tick_s, presc_clr_s;

  assign start_ev_s   = start & ~start_q;
  assign stop_ev_s    = stop & ~stop_q;
  assign lfsr_d       = lfsr_next(lfsr_q);
  assign delay_load_s = DLY_W'(DELAY_MIN_MS) + DLY_W'(lfsr_q[DELAY_BITS-1:0]);
  // Restart the prescaler on entry to WAIT or GO so the first ms is a full ms.
  assign presc_clr_s  = (state_d != state_q) && ((state_d == WAIT) || (state_d == GO));

  ms_tick_gen #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (presc_clr_s),
    .tick(tick_s)
  );

  // Next-state, delay and time computation.
  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    delay_d    = delay_q;
    time_inc_s = tick_s ? (time_q + MS_W'(1)) : time_q;
    case (state_q)
      IDLE, DONE, CHEAT: begin
        if (start_ev_s) begin
          state_d = WAIT;
          delay_d = delay_load_s;
          time_d  = '0;
        end else begin
          state_d = state_q;
        end
      end
      WAIT: begin
        if (stop_ev_s) begin
          state_d = CHEAT;
        end else if (tick_s && (delay_q == DLY_W'(1))) begin
          state_d = GO;
          time_d  = '0;
        end else if (tick_s) begin
          delay_d = delay_q - DLY_W'(1);
        end else begin
          delay_d = delay_q;
        end
      end
      GO: begin
        time_d = time_inc_s;
        if (stop_ev_s) begin
          state_d = DONE;
        end else if (time_inc_s >= MAX_T) begin
          state_d = DONE;
          time_d  = MAX_T;
        end else begin
          state_d = GO;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers; button levels are sampled even in reset so held
  // buttons never produce an event when reset releases.
  always_ff @(posedge clk) begin
    start_q <= start;
    stop_q  <= stop;
    if (rst) begin
      state_q <= IDLE;
      time_q  <= '0;
      delay_q <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      delay_q <= delay_d;
      lfsr_q  <= lfsr_d;
    end
  end

`ifdef BEST_TIME_EN
  logic [MS_W-1:0] best_q, best_d;

  // Only stop-terminated rounds qualify; overflow leaves the record alone.
  always_comb begin
    if ((state_q == GO) && stop_ev_s && (time_d < best_q)) begin
      best_d = time_d;
    end else begin
      best_d = best_q;
    end
  end

  // Best-time register.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_q <= MAX_T;
    end else begin
      best_q <= best_d;
    end
  end

  assign best_ms = best_q;
`else
  assign best_ms = MAX_T;
`endif

  assign time_ms = time_q;
  assign state   = state_q;
  assign go_led  = (state_q == GO);
  assign done    = (state_q == DONE);
  assign cheat   = (state_q == CHEAT);

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer: randomized rounds against a
// timing model built from the ms/delay rules and a reference LFSR.
module tb_reaction_timer;

  localparam int CPM        = 4;
  localparam int DMIN       = 2;
  localparam int DBITS      = 2;
  localparam int MAXMS      = 20;
  localparam int GO_TIMEOUT = 200;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic [13:0] time_ms;
  logic [13:0] best_ms;
  logic        go_led, done, cheat;
  logic [2:0]  state;

  int          n_total  = 0;
  int          n_pass   = 0;
  int          ref_best = MAXMS;
  logic [15:0] ref_lfsr = 16'hACE1;

  always #5 clk = ~clk;

  reaction_timer #(
    .CLK_PER_MS  (CPM),
    .DELAY_MIN_MS(DMIN),
    .DELAY_BITS  (DBITS),
    .MAX_MS      (MAXMS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .time_ms(time_ms),
    .go_led (go_led),
    .done   (done),
    .cheat  (cheat),
    .state  (state),
    .best_ms(best_ms)
  );

  // x^16+x^14+x^13+x^11+1, right-shifting Galois step
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) ref_lfsr <= 16'hACE1;
    else     ref_lfsr <= lfsr_step(ref_lfsr);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic check_outs(input string tag, input int st, input int t);
    check({tag, ".state"}, 32'(state), st);
    check({tag, ".time"},  32'(time_ms), t);
    check({tag, ".go"},    32'(go_led), 32'(st == 2));
    check({tag, ".done"},  32'(done),   32'(st == 3));
    check({tag, ".cheat"}, 32'(cheat),  32'(st == 4));
    check({tag, ".best"},  32'(best_ms), ref_best);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ref_best = MAXMS;
    check_outs("reset", 0, 0);
  endtask

  // Press start (optionally with stop) after a random idle gap; returns the
  // wait in ms that the LFSR value at the event cycle selects.
  task automatic start_round(input logic with_stop, output int delay);
    logic [15:0] ev_lfsr;
    repeat ($urandom_range(0, 7)) @(negedge clk);
    ev_lfsr = ref_lfsr;
    delay   = DMIN + int'(ev_lfsr[DBITS-1:0]);
    start = 1'b1; stop = with_stop;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check_outs("wait_entry", 1, 0);
  endtask

  task automatic wait_go(input int delay, input string tag);
    int cyc;
    cyc = 1;
    while (go_led !== 1'b1 && cyc < GO_TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".go_latency"}, cyc, 1 + CPM * delay);
    check({tag, ".go_time"}, 32'(time_ms), 0);
  endtask

  // Stop m cycles after GO is seen: the count is completed ms, capped at MAXMS.
  task automatic play_round(input int m, input logic both_start, input logic both_stop,
                            input string tag);
    int d, exp_t;
    start_round(both_start, d);
    wait_go(d, tag);
    repeat (m) @(negedge clk);
    stop = 1'b1; start = both_stop;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    exp_t = (m + 1) / CPM;
    if (exp_t > MAXMS) exp_t = MAXMS;
`ifdef BEST_TIME_EN
    if (exp_t < ref_best) ref_best = exp_t;
`endif
    check_outs(tag, 3, exp_t);
  endtask

  // j_sel < 0 selects the last WAIT cycle, where stop meets the GO-entry tick.
  task automatic cheat_round(input int j_sel, input string tag);
    int   d, j;
    logic seen_go;
    start_round(1'b0, d);
    j = (j_sel < 0) ? (CPM * d - 1) : (j_sel % (CPM * d));
    seen_go = 1'b0;
    repeat (j) begin
      @(negedge clk);
      seen_go = seen_go | go_led;
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    seen_go = seen_go | go_led;
    check({tag, ".go_never"}, 32'(seen_go), 0);
    check_outs(tag, 4, 0);
  endtask

  initial begin
    int d;
    int best_exp[4];
    int rt[3];

    do_reset();

    play_round(CPM * 7, 1'b0, 1'b0, "normal");

    cheat_round(-1, "cheat_edge");
    cheat_round(int'($urandom_range(0, 30)), "cheat_rand");

    start_round(1'b0, d);
    wait_go(d, "ovf");
    repeat (CPM * MAXMS - 1) @(negedge clk);
    check_outs("ovf_pre", 2, MAXMS - 1);
    @(negedge clk);
    check_outs("ovf_sat", 3, MAXMS);
    repeat (50 * CPM) @(negedge clk);
    check_outs("ovf_hold", 3, MAXMS);

    start_round(1'b0, d);
    wait_go(d, "rstgo");
    repeat (3 * CPM) @(negedge clk);
    check("rstgo.t3", 32'(time_ms), 3);
    rst = 1'b1; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    ref_best = MAXMS;
    check_outs("rst_mid_go", 0, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_outs("rst_held_btn", 0, 0);
    start = 1'b0; stop = 1'b0;
    @(negedge clk);

    play_round(CPM * 5 + 1, 1'b1, 1'b1, "simul");
    repeat (3) @(negedge clk);
    check_outs("simul_hold", 3, 5);

    do_reset();
    rt[0] = 9; rt[1] = 5; rt[2] = 12;
`ifdef BEST_TIME_EN
    best_exp[0] = 9; best_exp[1] = 5; best_exp[2] = 5; best_exp[3] = 5;
`else
    best_exp[0] = MAXMS; best_exp[1] = MAXMS; best_exp[2] = MAXMS; best_exp[3] = MAXMS;
`endif
    for (int i = 0; i < 3; i++) begin
      play_round(CPM * rt[i] - 1 + int'($urandom_range(0, CPM - 1)), 1'b0, 1'b0, "best_rnd");
      check("best_seq", 32'(best_ms), best_exp[i]);
    end
    play_round(CPM * MAXMS + 3, 1'b0, 1'b0, "best_ovf");
    check("best_seq_ovf", 32'(best_ms), best_exp[3]);

    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 2) == 2) cheat_round(int'($urandom_range(0, 30)), "rand_cheat");
      else play_round(int'($urandom_range(0, CPM * MAXMS + 5)), 1'b0, 1'b0, "rand_round");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
